// File: rtl/tt_uart_tx.sv
// ============================================================================
// Module   : tt_uart_tx
// Purpose  : Asynchronous serial transmitter. Accepts one parallel word via a
//            valid/ready handshake and shifts it out as a start bit, DATA_BITS
//            data bits (LSB first), an optional parity bit and STOP_BITS stop
//            bits, each bit lasting CLKS_PER_BIT clock cycles.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            ena      - enable; gates acceptance of new frames only
//            tx_data  - word to send, sampled on the accept edge
//            tx_valid - source has a word
//            tx_ready - block can accept a word (IDLE && ena)
//            tx       - serial line, idles high
//            busy     - a frame is in progress
//            tx_done  - one-cycle pulse at end of frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q,   par_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             baud_end;
  logic [7:0]       data_masked;

  assign tx_ready    = (state_q == S_IDLE) && ena;
  assign baud_end    = (baud_q == BAUD_LAST);
  assign data_masked = tx_data & DATA_MASK;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && tx_ready) begin
          // tx drops on the accept edge itself so the start bit is a full period
          state_d = S_START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          shift_d = data_masked;
          par_d   = (^data_masked) ^ 1'(PARITY_ODD);
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            // next data bit is the one that lands in bit 0 after this shift
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_uart_tx.sv
// ============================================================================
// Module   : tb_tt_uart_tx
// Purpose  : Self-checking bench for tt_uart_tx. Five instances with different
//            parameter sets share one stimulus stream; a frame-level model
//            predicts every output of every instance each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_uart_tx;

  localparam int NI   = 5;
  localparam int NCAP = 96;
  localparam int P_CPB  [NI] = '{4, 4, 4, 3, 1};
  localparam int P_DB   [NI] = '{8, 8, 8, 5, 7};
  localparam int P_PEN  [NI] = '{0, 1, 1, 1, 0};
  localparam int P_PODD [NI] = '{0, 0, 1, 0, 0};
  localparam int P_SB   [NI] = '{1, 1, 1, 2, 2};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [NI-1:0] tx_w, busy_w, done_w, ready_w;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic wtx   [NI][NCAP];
  logic wbusy [NI][NCAP];
  logic wdone [NI][NCAP];

  always #5 clk = ~clk;

  tt_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  tt_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  tt_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  tt_uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));
  tt_uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]));

  // ---------------- frame-level reference model ----------------
  function automatic int flen(input int i);
    return P_CPB[i] * (1 + P_DB[i] + P_PEN[i] + P_SB[i]);
  endfunction

  function automatic logic [7:0] dmask(input int i);
    return 8'((1 << P_DB[i]) - 1);
  endfunction

  // Line level k cycles after the accept edge, from the frame's bit list.
  function automatic logic fbit(input int i, input int k, input logic [7:0] d);
    int   b;
    logic p;
    b = k / P_CPB[i];
    if (b == 0) return 1'b0;
    if (b <= P_DB[i]) return d[b-1];
    if (P_PEN[i] != 0 && b == P_DB[i] + 1) begin
      p = (P_PODD[i] != 0);
      for (int j = 0; j < P_DB[i]; j++) p = p ^ d[j];
      return p;
    end
    return 1'b1;
  endfunction

  logic       m_act  [NI];
  int         m_k    [NI];
  logic       m_done [NI];
  logic [7:0] m_data [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i]  <= 1'b0;
        m_k[i]    <= 0;
        m_done[i] <= 1'b0;
        m_data[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] <= 1'b0;
        if (m_act[i]) begin
          if (m_k[i] + 1 == flen(i)) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_k[i] <= m_k[i] + 1;
          end
        end else if (tx_valid && ena) begin
          m_act[i]  <= 1'b1;
          m_k[i]    <= 0;
          m_data[i] <= tx_data & dmask(i);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t actual=%b required=%b", nm, i, $time, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  // Compare process: every cycle, every instance, every output.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("tx",    i, tx_w[i],    m_act[i] ? fbit(i, m_k[i], m_data[i]) : 1'b1);
        chk("busy",  i, busy_w[i],  m_act[i]);
        chk("done",  i, done_w[i],  m_done[i]);
        chk("ready", i, ready_w[i], !m_act[i] && ena);
      end
    end
  end

  // Sends d on one accept edge, then captures NCAP cycles of all outputs.
  // cyc index == cycles since the accept edge.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] d2,
                           input int hold, input int ena_drop, input int rst_at);
    int rel_at;
    rel_at = -1;
    for (int t = 0; t < 300; t++) begin
      if (busy_w == '0) break;
      @(posedge clk);
    end
    chk("idle_wait", 0, (busy_w == '0), 1'b1);
    @(posedge clk); #2;
    ena      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #2;
    if (hold == 0) tx_valid = 1'b0;
    tx_data = d2;
    for (int cyc = 0; cyc < NCAP; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        wtx[i][cyc]   = tx_w[i];
        wbusy[i][cyc] = busy_w[i];
        wdone[i][cyc] = done_w[i];
      end
      #1;
      if (hold > 0 && cyc == hold) tx_valid = 1'b0;
      if (cyc == ena_drop) ena = 1'b0;
      if (cyc == rel_at) rst_n = 1'b1;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tx_async", 0, tx_w[0], 1'b1);
        chk("rst_busy", 0, busy_w[0], 1'b0);
        rel_at = cyc + 3;
      end
    end
    tx_valid = 1'b0;
    ena      = 1'b1;
  endtask

  function automatic int count_ones(input int i, input bit use_done);
    int c;
    c = 0;
    for (int k = 0; k < NCAP; k++) c += use_done ? int'(wdone[i][k]) : int'(wbusy[i][k]);
    return c;
  endfunction

  logic [9:0] fr;
  logic [7:0] b8;

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx",    0, tx_w[0],    1'b1);
    chk("rst_busy",  0, busy_w[0],  1'b0);
    chk("rst_done",  0, done_w[0],  1'b0);
    chk("rst_ready", 0, ready_w[0], 1'b1);
    ena = 1'b0;
    #1;
    chk("rst_ready_ena0", 0, ready_w[0], 1'b0);
    ena = 1'b1;
    #1 rst_n = 1'b1;

    // single 0xA5 frame, literal waveform
    run_frame(8'hA5, 8'hA5, 0, -1, -1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) chk("a5_bit", 0, wtx[0][b*4+2], fr[b]);
    chk_int("a5_busy_cycles", count_ones(0, 1'b0), 40);
    chk("a5_done_at_40", 0, wdone[0][40], 1'b1);
    chk_int("a5_done_count", count_ones(0, 1'b1), 1);

    // parity
    run_frame(8'h07, 8'h07, 0, -1, -1);
    chk("par_07_even", 1, wtx[1][38], 1'b1);
    chk("par_07_odd",  2, wtx[2][38], 1'b0);
    chk_int("par_busy_cycles", count_ones(1, 1'b0), 44);
    chk("par_done_at_44", 1, wdone[1][44], 1'b1);
    run_frame(8'h03, 8'h03, 0, -1, -1);
    chk("par_03_even", 1, wtx[1][38], 1'b0);
    chk("par_03_odd",  2, wtx[2][38], 1'b1);

    // back-to-back: valid held, data changes mid-frame
    run_frame(8'h55, 8'hFF, 50, -1, -1);
    b8 = 8'h55;
    for (int b = 1; b <= 8; b++) chk("b2b_55_bit", 0, wtx[0][b*4+2], b8[b-1]);
    chk("b2b_done_40", 0, wdone[0][40], 1'b1);
    chk("b2b_gap_high", 0, wtx[0][40], 1'b1);
    chk("b2b_start2", 0, wtx[0][41], 1'b0);
    chk("b2b_busy2", 0, wbusy[0][41], 1'b1);
    for (int b = 1; b <= 8; b++) chk("b2b_ff_bit", 0, wtx[0][41+b*4+2], 1'b1);

    // enable gating
    @(posedge clk); #2;
    ena = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("ena0_tx",   0, tx_w[0],   1'b1);
      chk("ena0_busy", 0, busy_w[0], 1'b0);
    end
    #1;
    tx_valid = 1'b0;
    ena = 1'b1;
    run_frame(8'hC3, 8'hC3, 0, 10, -1);
    chk("ena_drop_done", 0, wdone[0][40], 1'b1);
    chk_int("ena_drop_busy", count_ones(0, 1'b0), 40);

    // reset mid-frame, then a clean frame
    run_frame(8'h3C, 8'h3C, 0, -1, 15);
    chk_int("rst_mid_no_done", count_ones(0, 1'b1), 0);
    run_frame(8'h81, 8'h81, 0, -1, -1);
    fr = {1'b1, 8'h81, 1'b0};
    for (int b = 0; b < 10; b++) chk("x81_bit", 0, wtx[0][b*4+2], fr[b]);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      tx_valid = ($urandom_range(0, 3) == 0);
      ena      = ($urandom_range(0, 7) != 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
      end
    end
    @(posedge clk); #2;
    tx_valid = 1'b0;
    ena = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
